// File: rtl/wb_pkg.sv
// Shared definitions for the writeback sequencer.
//   WB_AW / WB_DW : default register address and data widths
//   PORT_RD       : entry targets register-file write port 1 (Rd)
//   PORT_BASE     : entry targets register-file write port 2 (Rs1 base update)
//   wb_entry_t    : queue entry layout at the default widths {port, addr, data}
package wb_pkg;

    localparam int unsigned WB_AW = 4;
    localparam int unsigned WB_DW = 32;

    localparam logic PORT_RD   = 1'b0;
    localparam logic PORT_BASE = 1'b1;

    typedef struct packed {
        logic               port;
        logic [WB_AW-1:0]   addr;
        logic [WB_DW-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_sequencer_queue.sv
// Circular pending-write FIFO: up to two pushes and one pop per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_n     : number of entries written this edge (0..2); din0 goes first
//   din0, din1 : entries to write
//   pop        : remove head this edge (ignored while empty)
//   head       : oldest entry
//   count      : number of valid entries (0..DEPTH)
//   age_ent    : entries ordered oldest (0) to youngest, for the bypass search
//   age_vld    : validity of each age_ent slot
module wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 37
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    push_n,
    input  logic [W-1:0]                  din0,
    input  logic [W-1:0]                  din1,
    input  logic                          pop,
    output logic [W-1:0]                  head,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH-1:0][W-1:0]       age_ent,
    output logic [DEPTH-1:0]              age_vld
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [W-1:0]  mem [DEPTH];
    logic          do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    // Pointers are PW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(do_pop);
            wr_ptr <= wr_ptr + PW'(push_n);
            count  <= count + CW'(push_n) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_n != 2'd0) mem[wr_ptr] <= din0;
        if (push_n == 2'd2) mem[wr_ptr + 1'b1] <= din1;
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age_ent[i] = mem[rd_ptr + PW'(i)];
            age_vld[i] = CW'(i) < count;
        end
    end

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: queues Rd and base-update results and issues them to
// the register file one write per cycle, with read bypass of pending writes.
//   wb_valid/wb_ready        : request handshake (ready needs two free entries)
//   wb_rd_en/wb_rd/...       : Rd result (port 1)
//   wb_base_en/wb_base/...   : base post-increment result (port 2)
//   rf_we1/rf_waddr1/...     : register-file write port 1
//   rf_we2/rf_waddr2/...     : register-file write port 2
//   rd_addr_a/b, fwd_*       : bypass lookup, youngest pending write wins
//   split_cnt                : saturating count of two-entry requests
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = WB_AW,
    parameter int unsigned DW    = WB_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic          wb_rd_en,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_rd_data,
    input  logic          wb_base_en,
    input  logic [AW-1:0] wb_base,
    input  logic [DW-1:0] wb_base_data,
    output logic          rf_we1,
    output logic [AW-1:0] rf_waddr1,
    output logic [DW-1:0] rf_wdata1,
    output logic          rf_we2,
    output logic [AW-1:0] rf_waddr2,
    output logic [DW-1:0] rf_wdata2,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic          fwd_hit_a,
    output logic [DW-1:0] fwd_data_a,
    output logic          fwd_hit_b,
    output logic [DW-1:0] fwd_data_b,
    output logic [15:0]   split_cnt
);

    typedef struct packed {
        logic          port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    localparam int unsigned EW = 1 + AW + DW;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                     accept;
    logic                     rd_w;
    logic                     base_w;
    logic [1:0]               push_n;
    entry_t                   rd_e;
    entry_t                   base_e;
    entry_t                   din0;
    entry_t                   head_e;
    logic [EW-1:0]            q_head;
    logic [CW-1:0]            q_count;
    logic [DEPTH-1:0][EW-1:0] age_ent;
    logic [DEPTH-1:0]         age_vld;

    // Ready depends only on the registered occupancy.
    assign wb_ready = q_count <= CW'(DEPTH - 2);
    assign accept   = wb_valid && wb_ready;

    // Rd wins an address collision; R0 writes never enter the queue.
    assign rd_w   = wb_rd_en && (wb_rd != '0);
    assign base_w = wb_base_en && (wb_base != '0) && !(wb_rd_en && (wb_rd == wb_base));

    assign push_n = accept ? ({1'b0, rd_w} + {1'b0, base_w}) : 2'd0;

    assign rd_e   = '{port: PORT_RD,   addr: wb_rd,   data: wb_rd_data};
    assign base_e = '{port: PORT_BASE, addr: wb_base, data: wb_base_data};
    // A lone base write must land in the first slot.
    assign din0   = rd_w ? rd_e : base_e;

    wb_queue #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_n  (push_n),
        .din0    (din0),
        .din1    (base_e),
        .pop     (1'b1),
        .head    (q_head),
        .count   (q_count),
        .age_ent (age_ent),
        .age_vld (age_vld)
    );

    assign head_e = entry_t'(q_head);

    always_comb begin
        rf_we1    = 1'b0;
        rf_waddr1 = '0;
        rf_wdata1 = '0;
        rf_we2    = 1'b0;
        rf_waddr2 = '0;
        rf_wdata2 = '0;
        if (q_count != '0) begin
            if (head_e.port == PORT_RD) begin
                rf_we1    = 1'b1;
                rf_waddr1 = head_e.addr;
                rf_wdata1 = head_e.data;
            end else begin
                rf_we2    = 1'b1;
                rf_waddr2 = head_e.addr;
                rf_wdata2 = head_e.data;
            end
        end
    end

    // Scan oldest to youngest so the last match is the youngest.
    always_comb begin
        entry_t e;
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            e = entry_t'(age_ent[i]);
            if (age_vld[i] && (rd_addr_a != '0) && (e.addr == rd_addr_a)) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = e.data;
            end
            if (age_vld[i] && (rd_addr_b != '0) && (e.addr == rd_addr_b)) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = e.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_cnt <= '0;
        end else if (accept && rd_w && base_w && (split_cnt != 16'hFFFF)) begin
            split_cnt <= split_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
module tb_wb_sequencer;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_rd_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_rd_data;
    logic        wb_base_en;
    logic [3:0]  wb_base;
    logic [31:0] wb_base_data;
    logic        rf_we1;
    logic [3:0]  rf_waddr1;
    logic [31:0] rf_wdata1;
    logic        rf_we2;
    logic [3:0]  rf_waddr2;
    logic [31:0] rf_wdata2;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic        fwd_hit_a;
    logic [31:0] fwd_data_a;
    logic        fwd_hit_b;
    logic [31:0] fwd_data_b;
    logic [15:0] split_cnt;

    int total;
    int bad;

    wb_sequencer #(
        .DEPTH (4),
        .AW    (4),
        .DW    (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd_en     (wb_rd_en),
        .wb_rd        (wb_rd),
        .wb_rd_data   (wb_rd_data),
        .wb_base_en   (wb_base_en),
        .wb_base      (wb_base),
        .wb_base_data (wb_base_data),
        .rf_we1       (rf_we1),
        .rf_waddr1    (rf_waddr1),
        .rf_wdata1    (rf_wdata1),
        .rf_we2       (rf_we2),
        .rf_waddr2    (rf_waddr2),
        .rf_wdata2    (rf_wdata2),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .fwd_hit_a    (fwd_hit_a),
        .fwd_data_a   (fwd_data_a),
        .fwd_hit_b    (fwd_hit_b),
        .fwd_data_b   (fwd_data_b),
        .split_cnt    (split_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd_en, input logic [3:0] rd, input logic [31:0] rd_data,
                       input logic base_en, input logic [3:0] base, input logic [31:0] base_data);
        wb_valid     = 1'b1;
        wb_rd_en     = rd_en;
        wb_rd        = rd;
        wb_rd_data   = rd_data;
        wb_base_en   = base_en;
        wb_base      = base;
        wb_base_data = base_data;
    endtask

    task automatic idle();
        wb_valid     = 1'b0;
        wb_rd_en     = 1'b0;
        wb_rd        = '0;
        wb_rd_data   = '0;
        wb_base_en   = 1'b0;
        wb_base      = '0;
        wb_base_data = '0;
    endtask

    task automatic chk_w1(input string tag, input logic [3:0] a, input logic [31:0] d);
        check({tag, "_we1"},  rf_we1, 1);
        check({tag, "_a1"},   rf_waddr1, a);
        check({tag, "_d1"},   rf_wdata1, d);
        check({tag, "_we2"},  rf_we2, 0);
    endtask

    task automatic chk_w2(input string tag, input logic [3:0] a, input logic [31:0] d);
        check({tag, "_we2"},  rf_we2, 1);
        check({tag, "_a2"},   rf_waddr2, a);
        check({tag, "_d2"},   rf_wdata2, d);
        check({tag, "_we1"},  rf_we1, 0);
    endtask

    task automatic chk_none(input string tag);
        check({tag, "_we1"}, rf_we1, 0);
        check({tag, "_we2"}, rf_we2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "time limit");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        rd_addr_a = 4'd5;
        rd_addr_b = 4'd0;
        // request held during reset must be discarded
        req(1, 4'd5, 32'h55, 0, 4'd0, 32'h0);
        tick();
        tick();
        check("rst_we1", rf_we1, 0);
        check("rst_we2", rf_we2, 0);
        check("rst_ready", wb_ready, 1);
        check("rst_hita", fwd_hit_a, 0);
        check("rst_split", split_cnt, 0);
        rst_n = 1'b1;
        idle();
        tick();
        chk_none("rst_discard");
        check("rst_ready2", wb_ready, 1);

        // single Rd
        req(1, 4'd5, 32'hDEADBEEF, 0, 4'd0, 32'h0);
        tick();
        idle();
        chk_w1("single", 4'd5, 32'hDEADBEEF);
        check("single_a2", rf_waddr2, 0);
        tick();
        chk_none("single_empty");
        check("single_ready", wb_ready, 1);

        // LW.POI
        req(1, 4'd3, 32'h11, 1, 4'd7, 32'h104);
        tick();
        idle();
        chk_w1("poi_c1", 4'd3, 32'h11);
        check("poi_split", split_cnt, 1);
        tick();
        chk_w2("poi_c2", 4'd7, 32'h104);
        check("poi_a1zero", rf_waddr1, 0);
        check("poi_d1zero", rf_wdata1, 0);
        tick();
        chk_none("poi_empty");

        // collision: Rd wins
        req(1, 4'd4, 32'h44, 1, 4'd4, 32'h99);
        tick();
        idle();
        chk_w1("coll", 4'd4, 32'h44);
        check("coll_split", split_cnt, 1);
        tick();
        chk_none("coll_after");

        // R0 targets
        req(1, 4'd0, 32'h1234, 1, 4'd0, 32'h5678);
        tick();
        idle();
        chk_none("r0_c1");
        tick();
        chk_none("r0_c2");

        // base-only
        req(0, 4'd2, 32'h77, 1, 4'd9, 32'h90);
        tick();
        idle();
        chk_w2("base_only", 4'd9, 32'h90);
        tick();
        chk_none("base_only_after");

        // back-pressure with consecutive dual requests
        check("bp_t0_ready", wb_ready, 1);
        req(1, 4'd1, 32'hA1, 1, 4'd2, 32'hA2);
        tick();
        check("bp_t1_ready", wb_ready, 1);
        chk_w1("bp_t1", 4'd1, 32'hA1);
        req(1, 4'd3, 32'hB3, 1, 4'd8, 32'hB8);
        tick();
        check("bp_t2_ready", wb_ready, 0);
        chk_w2("bp_t2", 4'd2, 32'hA2);
        req(1, 4'd10, 32'hC10, 1, 4'd11, 32'hC11);
        tick();
        check("bp_t3_ready", wb_ready, 1);
        chk_w1("bp_t3", 4'd3, 32'hB3);
        tick();
        idle();
        check("bp_t4_ready", wb_ready, 0);
        chk_w2("bp_t4", 4'd8, 32'hB8);
        tick();
        check("bp_t5_ready", wb_ready, 1);
        chk_w1("bp_t5", 4'd10, 32'hC10);
        tick();
        chk_w2("bp_t6", 4'd11, 32'hC11);
        tick();
        chk_none("bp_t7");
        check("bp_split", split_cnt, 4);

        // bypass: queue holds (6,A) then (6,B)
        rd_addr_a = 4'd6;
        rd_addr_b = 4'd0;
        req(1, 4'd12, 32'h12C, 1, 4'd6, 32'hA);
        tick();
        check("byp_t1_hita", fwd_hit_a, 1);
        check("byp_t1_da", fwd_data_a, 32'hA);
        check("byp_t1_hitb", fwd_hit_b, 0);
        req(1, 4'd6, 32'hB, 0, 4'd0, 32'h0);
        tick();
        idle();
        check("byp_t2_hita", fwd_hit_a, 1);
        check("byp_t2_da", fwd_data_a, 32'hB);
        check("byp_t2_hitb", fwd_hit_b, 0);
        chk_w2("byp_t2_head", 4'd6, 32'hA);
        rd_addr_b = 4'd6;
        #1;
        check("byp_b6_hit", fwd_hit_b, 1);
        check("byp_b6_d", fwd_data_b, 32'hB);
        rd_addr_b = 4'd0;
        tick();
        chk_w1("byp_t3_head", 4'd6, 32'hB);
        check("byp_t3_da", fwd_data_a, 32'hB);
        tick();
        check("byp_t4_hita", fwd_hit_a, 0);
        check("byp_split", split_cnt, 5);

        // reset with three entries pending
        req(1, 4'd1, 32'h1, 1, 4'd2, 32'h2);
        tick();
        req(1, 4'd3, 32'h3, 1, 4'd4, 32'h4);
        tick();
        idle();
        check("mid_pre_ready", wb_ready, 0);
        check("mid_pre_split", split_cnt, 7);
        rst_n = 1'b0;
        #1;
        chk_none("mid_rst");
        check("mid_rst_ready", wb_ready, 1);
        check("mid_rst_split", split_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_none("mid_after1");
        check("mid_after_ready", wb_ready, 1);
        tick();
        chk_none("mid_after2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
